// File: rtl/eight_to_three_request_encoder_pkg.sv
// Shared constants and state type for the request encoder and its helpers.
// Default widths follow the 8-line / 3-bit index configuration.
package eight_to_three_request_encoder_pkg;

  localparam int N_DEF      = 8;
  localparam int CODE_W_DEF = $clog2(N_DEF);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SERVE = 1'b1;

  typedef enum logic {
    IDLE  = ST_IDLE,
    SERVE = ST_SERVE
  } state_t;

endpackage

// File: rtl/eight_to_three_request_encoder_lsb_priority_encoder.sv
// Combinational lowest-set-bit encoder: index of the lowest set bit, any-set and exactly-one-set flags.
// idx reads 0 when no bit is set, so callers can drive it straight out while idle.
module lsb_priority_encoder #(
  parameter  int N      = 8,
  localparam int CODE_W = $clog2(N)
) (
  input  logic [N-1:0]      i_in,
  output logic [CODE_W-1:0] o_idx,
  output logic              o_any,
  output logic              o_onehot
);

  // Scan from the top down so the lowest set bit writes last and wins.
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_in[i]) o_idx = CODE_W'(i);
    end
  end

  assign o_any    = |i_in;
  assign o_onehot = o_any && ((i_in & (i_in - N'(1))) == '0);

endmodule

// File: rtl/eight_to_three_request_encoder.sv
// Accepts a multi-hot request vector and emits the index of each set bit, lowest first, one per handshake.
// Latency: accept on edge k gives code_valid in cycle k+1; en low freezes all state.
module eight_to_three_request_encoder
  import eight_to_three_request_encoder_pkg::*;
#(
  parameter  int N      = N_DEF,
  localparam int CODE_W = $clog2(N)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [N-1:0]      i_req,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  output logic [CODE_W-1:0] o_code,
  output logic              o_code_valid,
  input  logic              i_code_ready,
  output logic              o_code_last,
  output logic [N-1:0]      o_pending,
  output logic              o_zero_err
);

  state_t              r_state;
  logic   [N-1:0]      r_pending;
  logic                r_zero_err;

  state_t              w_state_nxt;
  logic   [N-1:0]      w_pending_nxt;
  logic                w_zero_err_nxt;
  logic   [CODE_W-1:0] w_idx;
  logic                w_any;
  logic                w_onehot;
  logic                w_accept;
  logic                w_handshake;

  lsb_priority_encoder #(.N(N)) u_lsb_enc (
    .i_in    (r_pending),
    .o_idx   (w_idx),
    .o_any   (w_any),
    .o_onehot(w_onehot)
  );

  assign w_accept    = (r_state == IDLE)  && i_en && i_req_valid;
  assign w_handshake = (r_state == SERVE) && i_en && i_code_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_pending_nxt  = r_pending;
    w_zero_err_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (|i_req) begin
            w_pending_nxt = i_req;
            w_state_nxt   = SERVE;
          end else begin
            w_zero_err_nxt = 1'b1;
          end
        end
      end
      SERVE: begin
        // Clearing the lowest set bit retires exactly the code being presented.
        if (w_handshake) begin
          w_pending_nxt = r_pending & (r_pending - N'(1));
          if (w_onehot || !w_any) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_pending  <= '0;
      r_zero_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= w_pending_nxt;
      r_zero_err <= w_zero_err_nxt;
    end
  end

  assign o_req_ready  = !i_rst && i_en && (r_state == IDLE);
  assign o_code_valid = i_en && (r_state == SERVE);
  assign o_code       = w_idx;
  assign o_code_last  = (r_state == SERVE) && w_onehot;
  assign o_pending    = r_pending;
  assign o_zero_err   = r_zero_err;

endmodule

// File: tb/tb_eight_to_three_request_encoder.sv
// Bench for eight_to_three_request_encoder: directed scenarios plus randomized traffic against a queue-based model.
module tb_eight_to_three_request_encoder;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b1;
  logic [N-1:0] req = '0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] code;
  logic         code_valid;
  logic         code_ready = 1'b0;
  logic         code_last;
  logic [N-1:0] pending;
  logic         zero_err;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  eight_to_three_request_encoder dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_req       (req),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .o_code      (code),
    .o_code_valid(code_valid),
    .i_code_ready(code_ready),
    .o_code_last (code_last),
    .o_pending   (pending),
    .o_zero_err  (zero_err)
  );

  task automatic test_reset();
    #2;
    total++; if ({req_ready, code_valid, code, code_last, pending, zero_err} !== 15'h0) $display("FAIL reset_outputs got=%h exp=0", {req_ready, code_valid, code, code_last, pending, zero_err}); else passed++;
    @(negedge clk); rst = 1'b0; #1;
    total++; if (req_ready !== 1'b1) $display("FAIL reset_release_ready got=%b exp=1", req_ready); else passed++;
    total++; if (code_valid !== 1'b0) $display("FAIL reset_release_valid got=%b exp=0", code_valid); else passed++;
  endtask

  task automatic test_full_stream();
    logic [W-1:0] exp_code[4] = '{3'd1, 3'd2, 3'd5, 3'd7};
    logic [N-1:0] exp_pend[4] = '{8'hA6, 8'hA4, 8'hA0, 8'h80};
    @(negedge clk); req = 8'hA6; req_valid = 1'b1; code_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); req_valid = 1'b0; #1;
      total++; if (code_valid !== 1'b1 || code !== exp_code[i]) $display("FAIL stream_code[%0d] got=%0d/%b exp=%0d/1", i, code, code_valid, exp_code[i]); else passed++;
      total++; if (pending !== exp_pend[i]) $display("FAIL stream_pending[%0d] got=%h exp=%h", i, pending, exp_pend[i]); else passed++;
      total++; if (code_last !== (i == 3)) $display("FAIL stream_last[%0d] got=%b exp=%b", i, code_last, (i == 3)); else passed++;
    end
    @(negedge clk); #1;
    total++; if (req_ready !== 1'b1 || code_valid !== 1'b0) $display("FAIL stream_idle got=%b%b exp=10", req_ready, code_valid); else passed++;
  endtask

  task automatic test_backpressure();
    @(negedge clk); req = 8'h81; req_valid = 1'b1; code_ready = 1'b0;
    @(negedge clk); req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (code !== 3'd0 || pending !== 8'h81 || code_valid !== 1'b1 || code_last !== 1'b0) $display("FAIL bp_hold[%0d] got=%0d/%h/%b/%b exp=0/81/1/0", i, code, pending, code_valid, code_last); else passed++;
      @(negedge clk);
    end
    code_ready = 1'b1;
    @(negedge clk); #1;
    total++; if (code !== 3'd7 || code_last !== 1'b1 || pending !== 8'h80) $display("FAIL bp_release got=%0d/%b/%h exp=7/1/80", code, code_last, pending); else passed++;
    @(negedge clk);
  endtask

  task automatic test_zero_vector();
    @(negedge clk); req = 8'h00; req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0; #1;
    total++; if (zero_err !== 1'b1 || code_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL zero_pulse got=%b%b%b exp=101", zero_err, code_valid, req_ready); else passed++;
    @(negedge clk); #1;
    total++; if (zero_err !== 1'b0 || code_valid !== 1'b0) $display("FAIL zero_clear got=%b%b exp=00", zero_err, code_valid); else passed++;
  endtask

  task automatic test_enable_freeze();
    @(negedge clk); req = 8'h18; req_valid = 1'b1; code_ready = 1'b1;
    @(negedge clk); req_valid = 1'b0; en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (code_valid !== 1'b0 || pending !== 8'h18 || req_ready !== 1'b0) $display("FAIL freeze[%0d] got=%b/%h/%b exp=0/18/0", i, code_valid, pending, req_ready); else passed++;
      @(negedge clk);
    end
    en = 1'b1; #1;
    total++; if (code_valid !== 1'b1 || code !== 3'd3) $display("FAIL freeze_resume got=%b/%0d exp=1/3", code_valid, code); else passed++;
    @(negedge clk); #1;
    total++; if (code !== 3'd4 || code_last !== 1'b1) $display("FAIL freeze_second got=%0d/%b exp=4/1", code, code_last); else passed++;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    @(negedge clk); req = 8'hF0; req_valid = 1'b1; code_ready = 1'b0;
    @(negedge clk); req_valid = 1'b0; #1;
    total++; if (pending !== 8'hF0) $display("FAIL arst_pre got=%h exp=f0", pending); else passed++;
    #1 rst = 1'b1; #1;
    total++; if (pending !== 8'h00 || code_valid !== 1'b0 || code !== 3'd0 || req_ready !== 1'b0) $display("FAIL arst_immediate got=%h/%b/%0d/%b exp=00/0/0/0", pending, code_valid, code, req_ready); else passed++;
    #1 rst = 1'b0;
    @(negedge clk); req = 8'h01; req_valid = 1'b1; code_ready = 1'b1;
    @(negedge clk); req_valid = 1'b0; #1;
    total++; if (code_valid !== 1'b1 || code !== 3'd0 || code_last !== 1'b1) $display("FAIL arst_next got=%b/%0d/%b exp=1/0/1", code_valid, code, code_last); else passed++;
    @(negedge clk);
  endtask

  // Model: the set-bit indices still owed to the consumer, in ascending order.
  task automatic test_random();
    int           q[$];
    logic         zf = 1'b0;
    logic [N-1:0] exp_pend;
    logic         serving;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      en         = ($urandom_range(0, 7) != 0);
      code_ready = ($urandom_range(0, 3) != 0);
      req_valid  = ($urandom_range(0, 1) != 0);
      req        = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      #1;
      serving  = (q.size() > 0);
      exp_pend = '0;
      foreach (q[k]) exp_pend = exp_pend + (8'd1 << q[k]);
      total++; if (code_valid !== (en && serving)) $display("FAIL rnd_valid c%0d got=%b exp=%b", cyc, code_valid, en && serving); else passed++;
      total++; if (req_ready !== (en && !serving)) $display("FAIL rnd_ready c%0d got=%b exp=%b", cyc, req_ready, en && !serving); else passed++;
      total++; if (pending !== exp_pend) $display("FAIL rnd_pending c%0d got=%h exp=%h", cyc, pending, exp_pend); else passed++;
      total++; if (code !== (serving ? W'(q[0]) : 3'd0)) $display("FAIL rnd_code c%0d got=%0d exp=%0d", cyc, code, serving ? q[0] : 0); else passed++;
      total++; if (code_last !== (q.size() == 1)) $display("FAIL rnd_last c%0d got=%b exp=%b", cyc, code_last, q.size() == 1); else passed++;
      total++; if (zero_err !== zf) $display("FAIL rnd_zero_err c%0d got=%b exp=%b", cyc, zero_err, zf); else passed++;
      zf = 1'b0;
      if (en && serving && code_ready) begin
        void'(q.pop_front());
      end else if (en && !serving && req_valid) begin
        if (req == 8'h00) zf = 1'b1;
        for (int b = 0; b < N; b++) if (req[b]) q.push_back(b);
      end
    end
    @(negedge clk); en = 1'b1; req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_stream();
    test_backpressure();
    test_zero_vector();
    test_enable_freeze();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
